// File: rtl/dmem_pkg.sv
// Shared definitions for the banked data-memory controller: RV32 funct3 codes,
// controller state encoding and the store byte-mask helper.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    function automatic logic [3:0] byte_mask(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic [3:0] m;
        case (funct3)
            F3_B, F3_BU: m = 4'b0001 << addr_lo;
            F3_H, F3_HU: m = 4'b0011 << addr_lo;
            default:     m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dmem_banked_ctrl_if.sv
// Request/response bus between the MEM stage (master) and the data-memory
// controller (slave).
interface dmem_banked_ctrl_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for RV32 loads/stores: store mask and data shift, load
// extract and sign/zero extension, illegal/misaligned flags.
// DMEM_MISALIGN_TRAP_EN: flag misaligned h/w accesses instead of forcing alignment.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o,
    output logic        illegal_o
);

    logic [1:0]  lo;
    logic [4:0]  sh;
    logic [31:0] rsh;

    // Low address bits are always forced aligned; a trapping build also reports them.
    always_comb begin
        lo         = addr_lo_i;
        misalign_o = 1'b0;
        case (funct3_i[1:0])
            2'b01: begin
                lo = {addr_lo_i[1], 1'b0};
`ifdef DMEM_MISALIGN_TRAP_EN
                misalign_o = addr_lo_i[0];
`endif
            end
            2'b10: begin
                lo = 2'b00;
`ifdef DMEM_MISALIGN_TRAP_EN
                misalign_o = |addr_lo_i;
`endif
            end
            default: ;
        endcase
    end

    assign sh        = {lo, 3'b000};
    assign be_o      = byte_mask(funct3_i, lo);
    assign wdata_o   = wdata_i << sh;
    assign rsh       = rword_i >> sh;
    assign illegal_o = (funct3_i == 3'b011) || (funct3_i[2:1] == 2'b11) || (we_i && funct3_i[2]);

    always_comb begin
        rdata_o = '0;
        case (funct3_i)
            F3_B:    rdata_o = {{24{rsh[7]}}, rsh[7:0]};
            F3_H:    rdata_o = {{16{rsh[15]}}, rsh[15:0]};
            F3_W:    rdata_o = rsh;
            F3_BU:   rdata_o = {24'b0, rsh[7:0]};
            F3_HU:   rdata_o = {16'b0, rsh[15:0]};
            default: rdata_o = '0;
        endcase
    end

endmodule

// File: rtl/dmem_banked_ctrl.sv
// Data-memory controller with valid/ready handshake, RV32 sub-word access and
// configurable load latency. Optional macro: DMEM_MISALIGN_TRAP_EN.
module dmem_banked_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH        = 1024,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned ADDR_W       = 32
) (
    input logic               clk,
    input logic               rst,
    dmem_banked_ctrl_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = 4;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;

    logic [31:0]        mem [DEPTH];

    logic [ADDR_W-1:0]  addr;
    logic [IDX_W-1:0]   widx;
    logic               oor;
    logic               acc_err;
    logic               wr_en;
    logic [3:0]         be;
    logic [31:0]        wdata_sh;
    logic [31:0]        ld_data;
    logic               misalign;
    logic               illegal;

    assign addr    = bus.req_addr;
    assign widx    = addr[IDX_W+1:2];
    assign oor     = |(addr >> (IDX_W + 2));
    assign acc_err = oor | illegal | misalign;

    dmem_lane_align u_align (
        .we_i       (bus.req_we),
        .funct3_i   (bus.req_funct3),
        .addr_lo_i  (addr[1:0]),
        .wdata_i    (bus.req_wdata),
        .rword_i    (mem[widx]),
        .be_o       (be),
        .wdata_o    (wdata_sh),
        .rdata_o    (ld_data),
        .misalign_o (misalign),
        .illegal_o  (illegal)
    );

    // RAM contents survive reset; only the write strobe is suppressed while in reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (be[b]) mem[widx][8*b +: 8] <= wdata_sh[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        wr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    err_d   = acc_err;
                    rdata_d = (bus.req_we || acc_err) ? '0 : ld_data;
                    wr_en   = bus.req_we && !acc_err;
                    if (bus.req_we || READ_LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(READ_LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_d = IDLE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_dmem_banked_ctrl.sv
// Randomized bench for dmem_banked_ctrl: one instance with READ_LATENCY=1 and
// one with READ_LATENCY=4, each checked against a byte-addressed memory model.
module tb_dmem_banked_ctrl;
    import dmem_pkg::*;

    localparam int unsigned DEPTH = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_banked_ctrl_if #(.ADDR_W(32)) b1 ();
    dmem_banked_ctrl_if #(.ADDR_W(32)) b4 ();

    dmem_banked_ctrl #(.DEPTH(DEPTH), .READ_LATENCY(1), .ADDR_W(32)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    dmem_banked_ctrl #(.DEPTH(DEPTH), .READ_LATENCY(4), .ADDR_W(32)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (b4)
    );

    int unsigned n_chk = 0;
    int unsigned n_err = 0;
    logic [7:0]  mb [2][4*DEPTH];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic ready(input int d);
        return (d == 1) ? b4.req_ready : b1.req_ready;
    endfunction
    function automatic logic rvalid(input int d);
        return (d == 1) ? b4.resp_valid : b1.resp_valid;
    endfunction
    function automatic logic [31:0] rdata(input int d);
        return (d == 1) ? b4.resp_rdata : b1.resp_rdata;
    endfunction
    function automatic logic rerr(input int d);
        return (d == 1) ? b4.resp_err : b1.resp_err;
    endfunction
    function automatic int lat_of(input int d);
        return (d == 1) ? 4 : 1;
    endfunction

    task automatic drive(input int d, input logic v, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        if (d == 1) begin
            b4.req_valid = v; b4.req_we = we; b4.req_funct3 = f3; b4.req_addr = a; b4.req_wdata = wd;
        end else begin
            b1.req_valid = v; b1.req_we = we; b1.req_funct3 = f3; b1.req_addr = a; b1.req_wdata = wd;
        end
    endtask

    task automatic set_rr(input int d, input logic r);
        if (d == 1) b4.resp_ready = r;
        else        b1.resp_ready = r;
    endtask

    // Byte-addressed memory model: legality, range, alignment and extension rules.
    task automatic model(input int d, input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er, output int lat);
        int sz, off, base;
        bit legal;
        legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        sz    = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        lat   = we ? 1 : lat_of(d);
        rd    = '0;
        er    = !legal || (a >= 32'(4 * DEPTH));
        off   = int'(a[1:0]);
`ifdef DMEM_MISALIGN_TRAP_EN
        if (off % sz != 0) er = 1'b1;
`else
        off = off - (off % sz);
`endif
        if (!er) begin
            base = int'(a[15:0]) - int'(a[1:0]) + off;
            if (we) begin
                for (int i = 0; i < sz; i++) mb[d][base+i] = wd[8*i +: 8];
            end else begin
                for (int i = 0; i < sz; i++) rd[8*i +: 8] = mb[d][base+i];
                if (!f3[2] && sz == 1 && rd[7])  rd[31:8]  = '1;
                if (!f3[2] && sz == 2 && rd[15]) rd[31:16] = '1;
            end
        end
    endtask

    task automatic access(input int d, input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int hold, output logic [31:0] rd, output logic er);
        logic [31:0] erd;
        logic        eer;
        int          elat, lat, n;
        @(negedge clk);
        drive(d, 1'b1, we, f3, a, wd);
        n = 0;
        while (!ready(d) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready", 32'(ready(d)), 32'd1);
        model(d, we, f3, a, wd, erd, eer, elat);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        drive(d, 1'b0, 1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom);
        while (!rvalid(d) && lat < 40) begin
            chk("busy_ready", 32'(ready(d)), 32'd0);
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("resp_valid", 32'(rvalid(d)), 32'd1);
        chk("latency", 32'(lat), 32'(elat));
        chk("rdata", rdata(d), erd);
        chk("err", 32'(rerr(d)), 32'(eer));
        chk("resp_ready_low", 32'(ready(d)), 32'd0);
        rd = rdata(d);
        er = rerr(d);
        for (int k = 0; k < hold; k++) begin
            drive(d, 1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  32'($urandom_range(0, 4*DEPTH-1)), $urandom);
            @(posedge clk);
            @(negedge clk);
            chk("hold_valid", 32'(rvalid(d)), 32'd1);
            chk("hold_rdata", rdata(d), erd);
            chk("hold_err", 32'(rerr(d)), 32'(eer));
            chk("hold_ready", 32'(ready(d)), 32'd0);
        end
        drive(d, 1'b0, 1'b0, 3'd0, '0, '0);
        set_rr(d, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_rr(d, 1'b0);
        chk("idle_valid", 32'(rvalid(d)), 32'd0);
        chk("idle_ready", 32'(ready(d)), 32'd1);
        chk("idle_rdata", rdata(d), 32'd0);
        chk("idle_err", 32'(rerr(d)), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, w0, a;
        logic        er, we;
        logic [2:0]  f3;
        int          n, pick;

        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 3'd0, '0, '0);
        drive(1, 1'b0, 1'b0, 3'd0, '0, '0);
        set_rr(0, 1'b0);
        set_rr(1, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk("rst_ready", 32'(ready(d)), 32'd1);
            chk("rst_valid", 32'(rvalid(d)), 32'd0);
            chk("rst_rdata", rdata(d), 32'd0);
            chk("rst_err", 32'(rerr(d)), 32'd0);
        end

        for (int d = 0; d < 2; d++)
            for (int w = 0; w < int'(DEPTH); w++)
                access(d, 1'b1, F3_W, 32'(w * 4), $urandom, 0, rd, er);

        // Directed sequence, READ_LATENCY=1
        access(0, 1'b1, F3_W, 32'h10, 32'hDEADBEEF, 0, rd, er);
        chk("sw_err", 32'(er), 32'd0);
        access(0, 1'b0, F3_W, 32'h10, '0, 0, rd, er);
        chk("lw_deadbeef", rd, 32'hDEADBEEF);
        access(0, 1'b1, F3_B, 32'h11, 32'h7F, 0, rd, er);
        access(0, 1'b0, F3_W, 32'h10, '0, 0, rd, er);
        chk("lw_after_sb", rd, 32'hDEAD7FEF);
        access(0, 1'b0, F3_B, 32'h11, '0, 0, rd, er);
        chk("lb_7f", rd, 32'h0000007F);
        access(0, 1'b1, F3_B, 32'h13, 32'h80, 0, rd, er);
        access(0, 1'b0, F3_B, 32'h13, '0, 0, rd, er);
        chk("lb_80", rd, 32'hFFFFFF80);
        access(0, 1'b0, F3_BU, 32'h13, '0, 0, rd, er);
        chk("lbu_80", rd, 32'h00000080);
        access(0, 1'b0, F3_W, 32'h10, '0, 5, rd, er);
        chk("lw_hold", rd, 32'h80AD7FEF);
        access(0, 1'b0, F3_W, 32'(4 * DEPTH), '0, 0, rd, er);
        chk("oor_err", 32'(er), 32'd1);
        chk("oor_rdata", rd, 32'd0);
        access(0, 1'b1, 3'b011, 32'h10, 32'h12345678, 0, rd, er);
        chk("ill_err", 32'(er), 32'd1);
        access(0, 1'b0, F3_W, 32'h10, '0, 0, rd, er);
        chk("ill_nowrite", rd, 32'h80AD7FEF);
        access(0, 1'b0, F3_W, 32'h0, '0, 0, w0, er);
        access(0, 1'b1, F3_W, 32'h2, 32'hCAFEF00D, 0, rd, er);
`ifdef DMEM_MISALIGN_TRAP_EN
        chk("mis_err", 32'(er), 32'd1);
        access(0, 1'b0, F3_W, 32'h0, '0, 0, rd, er);
        chk("mis_nowrite", rd, w0);
`else
        chk("mis_err", 32'(er), 32'd0);
        access(0, 1'b0, F3_W, 32'h0, '0, 0, rd, er);
        chk("mis_aligned", rd, 32'hCAFEF00D);
`endif

        // Directed sequence, READ_LATENCY=4
        access(1, 1'b1, F3_H, 32'h12, 32'h8001, 0, rd, er);
        access(1, 1'b0, F3_H, 32'h12, '0, 0, rd, er);
        chk("lh_8001", rd, 32'hFFFF8001);

        @(negedge clk);
        drive(1, 1'b1, 1'b0, F3_H, 32'h12, '0);
        n = 0;
        while (!ready(1) && n < 40) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        drive(1, 1'b0, 1'b0, 3'd0, '0, '0);
        @(posedge clk);
        @(negedge clk);
        chk("wait_ready", 32'(ready(1)), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_valid", 32'(rvalid(1)), 32'd0);
        chk("abort_ready", 32'(ready(1)), 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("abort_valid2", 32'(rvalid(1)), 32'd0);
        access(1, 1'b0, F3_H, 32'h12, '0, 0, rd, er);
        chk("lh_after_rst", rd, 32'hFFFF8001);

        // Randomized traffic on both instances
        for (int d = 0; d < 2; d++) begin
            for (int it = 0; it < 150; it++) begin
                we = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 3) != 0) begin
                    pick = int'($urandom_range(0, we ? 2 : 4));
                    f3 = (pick == 3) ? F3_BU : (pick == 4) ? F3_HU : 3'(pick);
                end else begin
                    f3 = 3'($urandom_range(0, 7));
                end
                if ($urandom_range(0, 7) == 0)
                    a = ($urandom_range(0, 1) == 0) ? 32'(4*DEPTH + $urandom_range(0, 1000)) : ($urandom | 32'h8000_0000);
                else
                    a = 32'($urandom_range(0, 4*DEPTH-1));
                access(d, we, f3, a, $urandom, int'($urandom_range(0, 2)), rd, er);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
